// File: rtl/gigerx_pkg.sv
// Shared constants and types for the GMII receive byte packer.
package gigerx_pkg;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         STAT_LEN_W    = 16;

    typedef enum logic [1:0] {
        IDLE,
        PREAM,
        DATA,
        DROP
    } state_t;

    typedef struct packed {
        logic [STAT_LEN_W-1:0] len;
        logic                  err;
        logic                  ovf;
        logic                  long;
    } frm_stat_t;

endpackage

// File: rtl/gigerx_lane_shifter.sv
// Little-endian byte-lane packer with a one-word hold register and zero-padded flush.
module gigerx_lane_shifter #(
    parameter int WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           byte_en,
    input  logic [7:0]                     byte_in,
    input  logic                           flush,
    output logic                           hold_vld,
    output logic [WIDTH-1:0]               hold_data,
    output logic [$clog2(WIDTH/8):0]       hold_nb
);

    localparam int LANES = WIDTH / 8;
    localparam int KW    = $clog2(LANES);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_ins;
    logic [KW-1:0]    k;
    logic             last_lane;

    always_comb begin
        acc_ins            = acc;
        acc_ins[8*k +: 8]  = byte_in;
        last_lane          = (k == KW'(LANES - 1));
    end

    // acc is cleared on every issue so a flushed partial word carries zero upper lanes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            k         <= '0;
            hold_vld  <= 1'b0;
            hold_data <= '0;
            hold_nb   <= '0;
        end else begin
            hold_vld <= 1'b0;
            if (byte_en) begin
                if (last_lane) begin
                    hold_data <= acc_ins;
                    hold_nb   <= (KW+1)'(LANES);
                    hold_vld  <= 1'b1;
                    acc       <= '0;
                    k         <= '0;
                end else begin
                    acc <= acc_ins;
                    k   <= k + 1'b1;
                end
            end else if (flush && (k != '0)) begin
                hold_data <= acc;
                hold_nb   <= {1'b0, k};
                hold_vld  <= 1'b1;
                acc       <= '0;
                k         <= '0;
            end
        end
    end

endmodule

// File: rtl/gigerx_byte_packer.sv
// GMII receive packer: strips preamble/SFD, packs bytes into FIFO words, reports per-frame status.
module gigerx_byte_packer
    import gigerx_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int MAX_BYTES = 1522,
    parameter int LEN_W     = 16
) (
    input  logic             wrclk,
    input  logic             aclr,
    input  logic             rx_dv,
    input  logic             rx_er,
    input  logic [7:0]       rxd,
    output logic             wrreq,
    output logic [WIDTH-1:0] data,
    input  logic             full,
    output logic             frm_vld,
    output logic [LEN_W-1:0] frm_len,
    output logic             frm_err,
    output logic             frm_ovf,
    output logic             frm_long
);

    localparam int NBW = $clog2(WIDTH/8) + 1;
    localparam logic [LEN_W-1:0] MAX_CAP =
        (MAX_BYTES > (2**LEN_W - 1)) ? '1 : LEN_W'(MAX_BYTES);

    state_t state, state_nxt;
    logic   sof, eof, in_data, byte_en, at_max;

    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] wlen;
    logic [LEN_W-1:0] len_now;
    logic [LEN_W:0]   len_sum;
    logic             err_r, ovf_r, long_r, stat_pend;

    logic             hold_vld;
    logic [WIDTH-1:0] hold_data;
    logic [NBW-1:0]   hold_nb;
    frm_stat_t        stat;

    always_comb begin
        state_nxt = state;
        sof       = 1'b0;
        eof       = 1'b0;
        in_data   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_dv) begin
                    if (rxd == PREAMBLE_BYTE) begin
                        state_nxt = PREAM;
                    end else if (rxd == SFD_BYTE) begin
                        state_nxt = DATA;
                        sof       = 1'b1;
                    end else begin
                        state_nxt = DROP;
                    end
                end
            end
            PREAM: begin
                if (!rx_dv) begin
                    state_nxt = IDLE;
                end else if (rxd == SFD_BYTE) begin
                    state_nxt = DATA;
                    sof       = 1'b1;
                end else if (rxd != PREAMBLE_BYTE) begin
                    state_nxt = DROP;
                end
            end
            DATA: begin
                if (rx_dv) begin
                    in_data = 1'b1;
                end else begin
                    eof       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                if (!rx_dv) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        at_max  = (cnt >= MAX_CAP);
        byte_en = in_data & ~at_max;
        wrreq   = hold_vld & ~full;
        data    = hold_data;
        // Length includes the word being written this cycle, so the flush word lands in frm_len
        len_sum = {1'b0, wlen} + (LEN_W+1)'(wrreq ? hold_nb : '0);
        len_now = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
    end

    always_ff @(posedge wrclk or posedge aclr) begin
        if (aclr) begin
            state     <= IDLE;
            cnt       <= '0;
            wlen      <= '0;
            err_r     <= 1'b0;
            ovf_r     <= 1'b0;
            long_r    <= 1'b0;
            stat_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            stat_pend <= eof;
            if (sof) begin
                cnt    <= '0;
                wlen   <= '0;
                err_r  <= 1'b0;
                ovf_r  <= 1'b0;
                long_r <= 1'b0;
            end else begin
                if (byte_en)            cnt    <= cnt + 1'b1;
                if (in_data && at_max)  long_r <= 1'b1;
                if (in_data && rx_er)   err_r  <= 1'b1;
                if (hold_vld && full)   ovf_r  <= 1'b1;
                wlen <= len_now;
            end
        end
    end

    gigerx_lane_shifter #(
        .WIDTH (WIDTH)
    ) u_lane_shifter (
        .clk       (wrclk),
        .rst       (aclr),
        .byte_en   (byte_en),
        .byte_in   (rxd),
        .flush     (eof),
        .hold_vld  (hold_vld),
        .hold_data (hold_data),
        .hold_nb   (hold_nb)
    );

    always_comb begin
        stat = '0;
        if (stat_pend) begin
            stat.len  = STAT_LEN_W'(len_now);
            stat.err  = err_r;
            stat.ovf  = ovf_r | (hold_vld & full);
            stat.long = long_r;
        end
        frm_vld  = stat_pend;
        frm_len  = LEN_W'(stat.len);
        frm_err  = stat.err;
        frm_ovf  = stat.ovf;
        frm_long = stat.long;
    end

endmodule

// File: tb/tb_gigerx_byte_packer.sv
// Directed bench for gigerx_byte_packer with hand-computed expectations.
module tb_gigerx_byte_packer;

    logic        wrclk = 1'b0;
    logic        aclr  = 1'b1;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;
    logic [7:0]  rxd   = 8'h00;
    logic        full  = 1'b0;
    logic        wrreq;
    logic [63:0] data;
    logic        frm_vld;
    logic [15:0] frm_len;
    logic        frm_err;
    logic        frm_ovf;
    logic        frm_long;

    gigerx_byte_packer #(
        .WIDTH     (64),
        .MAX_BYTES (1522),
        .LEN_W     (16)
    ) dut (
        .wrclk    (wrclk),
        .aclr     (aclr),
        .rx_dv    (rx_dv),
        .rx_er    (rx_er),
        .rxd      (rxd),
        .wrreq    (wrreq),
        .data     (data),
        .full     (full),
        .frm_vld  (frm_vld),
        .frm_len  (frm_len),
        .frm_err  (frm_err),
        .frm_ovf  (frm_ovf),
        .frm_long (frm_long)
    );

    always #5 wrclk = ~wrclk;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    logic [63:0] wq[$];
    int          wr_cyc[$];
    int          stat_n = 0;
    int          st_cyc = 0;
    logic [15:0] st_len = '0;
    logic        st_err = 1'b0, st_ovf = 1'b0, st_long = 1'b0;

    always @(posedge wrclk) cyc <= cyc + 1;

    always @(negedge wrclk) begin
        if (wrreq) begin
            wq.push_back(data);
            wr_cyc.push_back(cyc);
            ntests++;
            assert (full === 1'b0) else begin
                nfail++;
                $error("FAIL wrreq_while_full: observed full=%0b expected 0", full);
            end
        end
        if (frm_vld) begin
            stat_n++;
            st_cyc  = cyc;
            st_len  = frm_len;
            st_err  = frm_err;
            st_ovf  = frm_ovf;
            st_long = frm_long;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wordat(input int idx);
        if (idx < wq.size()) return wq[idx];
        return 'x;
    endfunction

    function automatic logic [63:0] cycat(input int idx);
        if (idx < wr_cyc.size()) return 64'(wr_cyc[idx]);
        return 'x;
    endfunction

    task automatic step(input logic dv, input logic [7:0] d, input logic er, input logic f);
        @(posedge wrclk);
        #1;
        rx_dv = dv;
        rxd   = d;
        rx_er = er;
        full  = f;
    endtask

    task automatic clear_log();
        wq.delete();
        wr_cyc.delete();
        stat_n = 0;
    endtask

    // Byte i carries value i[7:0]; er_at/full_at select the byte index whose drive cycle gets rx_er/full.
    task automatic send_frame(input int n, input int er_at, input int full_at,
                              output int b7_drv, output int eof_drv);
        b7_drv = -1;
        for (int p = 0; p < 7; p++) step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'hD5, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            step(1'b1, i[7:0], (i == er_at), (i == full_at));
            if (i == 7) b7_drv = cyc;
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        eof_drv = cyc;
        for (int g = 0; g < 4; g++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    int b7, eofc;

    initial begin
        // Reset state
        repeat (3) @(posedge wrclk);
        @(negedge wrclk);
        chk("rst_wrreq", 64'(wrreq), 64'd0);
        chk("rst_frm_vld", 64'(frm_vld), 64'd0);
        chk("rst_data", data, 64'd0);
        @(posedge wrclk);
        #1 aclr = 1'b0;

        // 64-byte frame
        clear_log();
        send_frame(64, -1, -1, b7, eofc);
        chk("t1_writes", 64'(wq.size()), 64'd8);
        chk("t1_word0", wordat(0), 64'h0706050403020100);
        chk("t1_word7", wordat(7), 64'h3F3E3D3C3B3A3938);
        chk("t1_latency", cycat(0), 64'(b7 + 1));
        chk("t1_lastwr_cyc", cycat(7), 64'(eofc));
        chk("t1_vld_cnt", 64'(stat_n), 64'd1);
        chk("t1_vld_cyc", 64'(st_cyc), 64'(eofc + 1));
        chk("t1_len", 64'(st_len), 64'd64);
        chk("t1_flags", 64'({st_err, st_ovf, st_long}), 64'd0);

        // 60-byte frame, zero-padded flush
        clear_log();
        send_frame(60, -1, -1, b7, eofc);
        chk("t2_writes", 64'(wq.size()), 64'd8);
        chk("t2_flush_word", wordat(7), 64'h000000003B3A3938);
        chk("t2_flush_cyc", cycat(7), 64'(eofc + 1));
        chk("t2_vld_cyc", 64'(st_cyc), 64'(eofc + 1));
        chk("t2_len", 64'(st_len), 64'd60);

        // full during the 3rd word's issue cycle
        clear_log();
        send_frame(64, -1, 24, b7, eofc);
        chk("t3_writes", 64'(wq.size()), 64'd7);
        chk("t3_word2", wordat(2), 64'h1F1E1D1C1B1A1918);
        chk("t3_len", 64'(st_len), 64'd56);
        chk("t3_ovf", 64'(st_ovf), 64'd1);

        // 1600-byte frame truncated to 1522
        clear_log();
        send_frame(1600, -1, -1, b7, eofc);
        chk("t4_writes", 64'(wq.size()), 64'd191);
        chk("t4_last_word", wordat(190), 64'h000000000000F1F0);
        chk("t4_len", 64'(st_len), 64'd1522);
        chk("t4_long", 64'(st_long), 64'd1);

        // rx_er on byte 10
        clear_log();
        send_frame(64, 10, -1, b7, eofc);
        chk("t5_err", 64'(st_err), 64'd1);
        chk("t5_word1", wordat(1), 64'h0F0E0D0C0B0A0908);
        chk("t5_len", 64'(st_len), 64'd64);

        // corrupted preamble
        clear_log();
        for (int p = 0; p < 3; p++) step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'h57, 1'b0, 1'b0);
        step(1'b1, 8'hD5, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, i[7:0], 1'b0, 1'b0);
        for (int g = 0; g < 5; g++) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t6_writes", 64'(wq.size()), 64'd0);
        chk("t6_vld_cnt", 64'(stat_n), 64'd0);

        // aclr mid-frame, then a clean 16-byte frame
        clear_log();
        for (int p = 0; p < 7; p++) step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b1, 8'hD5, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, i[7:0], 1'b0, 1'b0);
        @(posedge wrclk);
        #1;
        aclr  = 1'b1;
        rx_dv = 1'b0;
        for (int g = 0; g < 2; g++) step(1'b0, 8'h00, 1'b0, 1'b0);
        aclr = 1'b0;
        for (int g = 0; g < 4; g++) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t7_abort_vld", 64'(stat_n), 64'd0);
        clear_log();
        send_frame(16, -1, -1, b7, eofc);
        chk("t7_writes", 64'(wq.size()), 64'd2);
        chk("t7_word1", wordat(1), 64'h0F0E0D0C0B0A0908);
        chk("t7_vld_cnt", 64'(stat_n), 64'd1);
        chk("t7_len", 64'(st_len), 64'd16);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
